// File: rtl/pipe_ctrl.sv
// Pipelined MIPS main decoder: D-stage decode with registered E/M/W control bundles.
// Optional extended immediate/bne decodes under PIPE_CTRL_EXT_OPS_EN.
module pipe_ctrl #(
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         op_d,
    input  logic               valid_d,
    input  logic               stall_d,
    input  logic               flush_e,
    output logic               branch_d,
    output logic               bne_d,
    output logic               jump_d,
    output logic               illegal_d,
    output logic               regwrite_e,
    output logic               memtoreg_e,
    output logic               memwrite_e,
    output logic               alusrc_e,
    output logic               regdst_e,
    output logic               zeroext_e,
    output logic [ALUOP_W-1:0] aluop_e,
    output logic               regwrite_m,
    output logic               memtoreg_m,
    output logic               memwrite_m,
    output logic               regwrite_w,
    output logic               memtoreg_w,
    output logic [CNT_W-1:0]   illegal_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef PIPE_CTRL_EXT_OPS_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
`endif

    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       memwrite;
        logic       memtoreg;
        logic [2:0] aluop;
        logic       jump;
        logic       bne;
        logic       zeroext;
    } dec_t;

    typedef struct packed {
        logic               regwrite;
        logic               memtoreg;
        logic               memwrite;
        logic               alusrc;
        logic               regdst;
        logic               zeroext;
        logic [ALUOP_W-1:0] aluop;
    } ex_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } mem_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_t;

    generate
        if (ALUOP_W < 2) begin : g_aluop_min
            $error("pipe_ctrl: ALUOP_W must be >= 2");
        end
`ifdef PIPE_CTRL_EXT_OPS_EN
        if (ALUOP_W < 3) begin : g_aluop_ext
            $error("pipe_ctrl: ALUOP_W must be >= 3 with extended ops");
        end
`endif
    endgenerate

    dec_t dec;
    logic known;
    ex_t  dec_e;
    ex_t  e_q;
    mem_t m_q;
    wb_t  w_q;
    logic issue;

    always_comb begin
        dec   = '0;
        known = 1'b0;
        unique case (1'b1)
            (op_d == OP_RTYPE): begin
                known        = 1'b1;
                dec.regwrite = 1'b1;
                dec.regdst   = 1'b1;
                dec.aluop    = 3'd2;
            end
            (op_d == OP_LW): begin
                known        = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memtoreg = 1'b1;
            end
            (op_d == OP_SW): begin
                known        = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
            end
            (op_d == OP_BEQ): begin
                known      = 1'b1;
                dec.branch = 1'b1;
                dec.aluop  = 3'd1;
            end
            (op_d == OP_ADDI): begin
                known        = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            (op_d == OP_J): begin
                known    = 1'b1;
                dec.jump = 1'b1;
            end
`ifdef PIPE_CTRL_EXT_OPS_EN
            (op_d == OP_BNE): begin
                known     = 1'b1;
                dec.bne   = 1'b1;
                dec.aluop = 3'd1;
            end
            (op_d == OP_ANDI): begin
                known        = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.zeroext  = 1'b1;
                dec.aluop    = 3'd3;
            end
            (op_d == OP_ORI): begin
                known        = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.zeroext  = 1'b1;
                dec.aluop    = 3'd4;
            end
            (op_d == OP_SLTI): begin
                known        = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluop    = 3'd5;
            end
`endif
            default: begin
                dec   = '0;
                known = 1'b0;
            end
        endcase
        // An empty slot must never leak controls, even for a mapped opcode
        if (!valid_d) begin
            dec   = '0;
            known = 1'b0;
        end
    end

    assign illegal_d = valid_d & ~known;
    assign branch_d  = dec.branch;
    assign jump_d    = dec.jump;
`ifdef PIPE_CTRL_EXT_OPS_EN
    assign bne_d     = dec.bne;
`else
    assign bne_d     = 1'b0;
`endif

    always_comb begin
        dec_e          = '0;
        dec_e.regwrite = dec.regwrite;
        dec_e.memtoreg = dec.memtoreg;
        dec_e.memwrite = dec.memwrite;
        dec_e.alusrc   = dec.alusrc;
        dec_e.regdst   = dec.regdst;
`ifdef PIPE_CTRL_EXT_OPS_EN
        dec_e.zeroext  = dec.zeroext;
`else
        dec_e.zeroext  = 1'b0;
`endif
        dec_e.aluop    = ALUOP_W'(dec.aluop);
    end

    assign issue = ~stall_d & ~flush_e;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q          <= issue ? dec_e : '0;
            m_q.regwrite <= e_q.regwrite;
            m_q.memtoreg <= e_q.memtoreg;
            m_q.memwrite <= e_q.memwrite;
            w_q.regwrite <= m_q.regwrite;
            w_q.memtoreg <= m_q.memtoreg;
        end
    end

    // Only issued instructions count, so a stalled one is seen exactly once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_cnt <= '0;
        end else if (illegal_d && issue && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    assign regwrite_e = e_q.regwrite;
    assign memtoreg_e = e_q.memtoreg;
    assign memwrite_e = e_q.memwrite;
    assign alusrc_e   = e_q.alusrc;
    assign regdst_e   = e_q.regdst;
    assign zeroext_e  = e_q.zeroext;
    assign aluop_e    = e_q.aluop;
    assign regwrite_m = m_q.regwrite;
    assign memtoreg_m = m_q.memtoreg;
    assign memwrite_m = m_q.memwrite;
    assign regwrite_w = w_q.regwrite;
    assign memtoreg_w = w_q.memtoreg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected E bundles queued at drive time, popped after the edge.
// Runs with ALUOP_W=3 and CNT_W=3 so aluop 4/5 and counter saturation are both observable.
module tb_pipe_ctrl;

    localparam int AW = 3;
    localparam int CW = 3;

    logic          clk;
    logic          reset_n;
    logic [5:0]    op_d;
    logic          valid_d;
    logic          stall_d;
    logic          flush_e;
    logic          branch_d;
    logic          bne_d;
    logic          jump_d;
    logic          illegal_d;
    logic          regwrite_e;
    logic          memtoreg_e;
    logic          memwrite_e;
    logic          alusrc_e;
    logic          regdst_e;
    logic          zeroext_e;
    logic [AW-1:0] aluop_e;
    logic          regwrite_m;
    logic          memtoreg_m;
    logic          memwrite_m;
    logic          regwrite_w;
    logic          memtoreg_w;
    logic [CW-1:0] illegal_cnt;

    pipe_ctrl #(.ALUOP_W(AW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op_d       (op_d),
        .valid_d    (valid_d),
        .stall_d    (stall_d),
        .flush_e    (flush_e),
        .branch_d   (branch_d),
        .bne_d      (bne_d),
        .jump_d     (jump_d),
        .illegal_d  (illegal_d),
        .regwrite_e (regwrite_e),
        .memtoreg_e (memtoreg_e),
        .memwrite_e (memwrite_e),
        .alusrc_e   (alusrc_e),
        .regdst_e   (regdst_e),
        .zeroext_e  (zeroext_e),
        .aluop_e    (aluop_e),
        .regwrite_m (regwrite_m),
        .memtoreg_m (memtoreg_m),
        .memwrite_m (memwrite_m),
        .regwrite_w (regwrite_w),
        .memtoreg_w (memtoreg_w),
        .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // E bundle layout: {rw, mt, mw, as, rd, ze, aluop[2:0]}
    logic [8:0] exp_q[$];
    logic [8:0] mdl_e;
    logic [2:0] mdl_m;
    logic [1:0] mdl_w;
    logic [CW-1:0] mdl_cnt;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode: {branch, jump, bne} and the E bundle
    task automatic ref_dec(input logic [5:0] op, input logic v,
                           output logic [2:0] d, output logic [8:0] e,
                           output logic ill);
        d   = 3'b000;
        e   = 9'h000;
        ill = 1'b0;
        case (op)
            6'o00: e = {6'b100010, 3'd2};
            6'o43: e = {6'b110100, 3'd0};
            6'o53: e = {6'b001100, 3'd0};
            6'o04: begin d = 3'b100; e = {6'b000000, 3'd1}; end
            6'o10: e = {6'b100100, 3'd0};
            6'o02: d = 3'b010;
`ifdef PIPE_CTRL_EXT_OPS_EN
            6'o05: begin d = 3'b001; e = {6'b000000, 3'd1}; end
            6'o14: e = {6'b100101, 3'd3};
            6'o15: e = {6'b100101, 3'd4};
            6'o12: e = {6'b100100, 3'd5};
`endif
            default: ill = 1'b1;
        endcase
        if (!v) begin
            d   = 3'b000;
            e   = 9'h000;
            ill = 1'b0;
        end
    endtask

    function automatic logic [8:0] obs_e();
        return {regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e,
                zeroext_e, aluop_e};
    endfunction

    task automatic step(input logic [5:0] op, input logic v,
                        input logic s, input logic f);
        logic [2:0] d;
        logic [8:0] e;
        logic       ill;
        logic [8:0] got_e;
        @(negedge clk);
        op_d    = op;
        valid_d = v;
        stall_d = s;
        flush_e = f;
        #1;
        ref_dec(op, v, d, e, ill);
        chk("dcomb", {12'h0, branch_d, jump_d, bne_d, illegal_d}, {12'h0, d, ill});
        exp_q.push_back((s | f) ? 9'h000 : e);
        if (ill && !s && !f && mdl_cnt != '1) mdl_cnt = mdl_cnt + 1'b1;
        @(posedge clk);
        #1;
        mdl_w = {mdl_m[2], mdl_m[1]};
        mdl_m = mdl_e[8:6];
        if (exp_q.size() == 0) begin
            chk("qempty", 16'd0, 16'd1);
        end else begin
            mdl_e = exp_q.pop_front();
            got_e = obs_e();
            chk("e_stage", {7'h0, got_e}, {7'h0, mdl_e});
        end
        chk("m_stage", {13'h0, regwrite_m, memtoreg_m, memwrite_m}, {13'h0, mdl_m});
        chk("w_stage", {14'h0, regwrite_w, memtoreg_w}, {14'h0, mdl_w});
        chk("cnt", {13'h0, illegal_cnt}, {13'h0, mdl_cnt});
    endtask

    function automatic logic [15:0] all_regs();
        return {regwrite_m, memtoreg_m, memwrite_m, regwrite_w, memtoreg_w,
                illegal_cnt, 2'b00};
    endfunction

    logic [5:0] ops[12];

    initial begin
        ops = '{6'o00, 6'o43, 6'o53, 6'o04, 6'o10, 6'o02,
                6'o05, 6'o14, 6'o15, 6'o12, 6'o77, 6'o01};
        mdl_e   = '0;
        mdl_m   = '0;
        mdl_w   = '0;
        mdl_cnt = '0;
        reset_n = 1'b0;
        op_d    = 6'o43;
        valid_d = 1'b1;
        stall_d = 1'b0;
        flush_e = 1'b0;
        #3;
        chk("rst_e", {7'h0, obs_e()}, 16'h0);
        chk("rst_mw", all_regs(), 16'h0);
        #4;
        reset_n = 1'b1;

        // LW latency through E/M/W
        step(6'o43, 1'b1, 1'b0, 1'b0);
        chk("lw_e", {7'h0, obs_e()}, {7'h0, 6'b110100, 3'd0});
        step(6'o00, 1'b0, 1'b0, 1'b0);
        chk("lw_m", {13'h0, regwrite_m, memtoreg_m, memwrite_m}, 16'b110);
        step(6'o00, 1'b0, 1'b0, 1'b0);
        chk("lw_w", {14'h0, regwrite_w, memtoreg_w}, 16'b11);

        // SW held by stall for two cycles
        step(6'o53, 1'b1, 1'b1, 1'b0);
        step(6'o53, 1'b1, 1'b1, 1'b0);
        chk("sw_stall", {15'h0, memwrite_e}, 16'h0);
        step(6'o53, 1'b1, 1'b0, 1'b0);
        chk("sw_issue", {15'h0, memwrite_e}, 16'h1);

        // RTYPE flushed, then both stall and flush
        step(6'o00, 1'b1, 1'b0, 1'b1);
        chk("rt_flush", {14'h0, regwrite_e, regdst_e}, 16'h0);
        step(6'o00, 1'b1, 1'b1, 1'b1);
        step(6'o00, 1'b1, 1'b0, 1'b0);
        step(6'o04, 1'b1, 1'b0, 1'b0);
        step(6'o10, 1'b1, 1'b0, 1'b0);
        step(6'o02, 1'b1, 1'b0, 1'b0);
        step(6'o43, 1'b0, 1'b0, 1'b0);

        // Illegal 111111 three times, one stalled then re-presented
        step(6'o77, 1'b1, 1'b0, 1'b0);
        step(6'o77, 1'b1, 1'b1, 1'b0);
        step(6'o77, 1'b1, 1'b0, 1'b0);
        step(6'o77, 1'b1, 1'b0, 1'b0);
        chk("ill_cnt3", {13'h0, illegal_cnt}, 16'd3);

        // Extended ops: decoded, or illegal and counted
        step(6'o15, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_CTRL_EXT_OPS_EN
        chk("ori", {12'h0, regwrite_e, zeroext_e, aluop_e}, {12'h0, 2'b11, 3'd4});
`else
        chk("ori_cnt", {13'h0, illegal_cnt}, 16'd4);
`endif
        step(6'o05, 1'b1, 1'b0, 1'b0);
        step(6'o14, 1'b1, 1'b0, 1'b0);
        step(6'o12, 1'b1, 1'b0, 1'b0);

        // Saturation at 7
        for (int i = 0; i < 6; i++) step(6'o01, 1'b1, 1'b0, 1'b0);
        chk("sat", {13'h0, illegal_cnt}, 16'd7);

        for (int i = 0; i < 40; i++) begin
            step(ops[$urandom_range(0, 11)], 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0));
        end

        // Reset mid-pipeline with LW in E and M
        step(6'o43, 1'b1, 1'b0, 1'b0);
        step(6'o43, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_e", {7'h0, obs_e()}, 16'h0);
        chk("mid_rst_mw", all_regs(), 16'h0);
        mdl_e   = '0;
        mdl_m   = '0;
        mdl_w   = '0;
        mdl_cnt = '0;
        #2;
        reset_n = 1'b1;
        step(6'o43, 1'b1, 1'b0, 1'b0);
        chk("post_rst", {7'h0, obs_e()}, {7'h0, 6'b110100, 3'd0});
        step(6'o00, 1'b0, 1'b0, 1'b0);
        step(6'o00, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
